// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage with req/ack data-memory handshake, upstream stall and timeout abort
module mem_stage #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_in,
  input  logic [31:0] st_data_in,
  input  logic        mem_w_in,
  input  logic        mem_r_in,
  input  logic        wb_en_in,
  input  logic [4:0]  reg_dest_in,
  input  logic        terminate_in,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic        wb_en_out,
  output logic [4:0]  reg_dest_out,
  output logic [31:0] wb_data_out,
  output logic        terminate_out,
  output logic        mem_err
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);
  logic [0:0] state;
  logic [7:0] cnt;
  logic       mem_op;
  logic       timeout;
  logic       ld;
  // request decode, abort detect, real-instruction load enable and upstream stall
  always_comb begin
    mem_op  = mem_r_in | mem_w_in;
    timeout = state == WAIT && !dm_ack && cnt == LAST;
    ld      = state == IDLE ? !mem_op : dm_ack;
    stall   = rst_n && (state == IDLE ? mem_op : !dm_ack && cnt != LAST);
  end
  // handshake FSM, timeout counter, sticky error and MEM/WB register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      dm_req        <= 1'b0;
      dm_we         <= 1'b0;
      dm_addr       <= 32'd0;
      dm_wdata      <= 32'd0;
      wb_en_out     <= 1'b0;
      reg_dest_out  <= 5'd0;
      wb_data_out   <= 32'd0;
      terminate_out <= 1'b0;
      mem_err       <= 1'b0;
    end else begin
      if (state == IDLE && mem_op) begin
        state    <= WAIT;
        cnt      <= 8'd0;
        dm_req   <= 1'b1;
        dm_we    <= mem_w_in;
        dm_addr  <= alu_in;
        dm_wdata <= st_data_in;
      end else if (state == WAIT) begin
        if (dm_ack || timeout) begin
          state  <= IDLE;
          dm_req <= 1'b0;
        end else cnt <= cnt + 8'd1;
      end
      wb_en_out     <= ld & wb_en_in;
      terminate_out <= (ld | timeout) & terminate_in;
      reg_dest_out  <= ld | timeout ? reg_dest_in : reg_dest_out;
      wb_data_out   <= timeout ? 32'd0 : ld ? (state == WAIT && !dm_we ? dm_rdata : alu_in) : wb_data_out;
      mem_err       <= mem_err | timeout;
    end
  end
endmodule
